test_runner: RTL and testbench

Synthesizable sequencer that sits directly downstream of generated test modules: it drives each module's method request, watches its busy/return handshake, and folds the results into a pass/fail verdict. It replaces free-running testbench counters with a deterministic controller usable both in simulation and on an FPGA board, where `pass` and `done` drive LEDs.

---
 rtl/test_runner_pkg.sv | 16 +
 rtl/test_runner_timer.sv | 26 ++
 rtl/test_runner.sv | 165 ++++++++++++++++
 tb/tb_test_runner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/test_runner_pkg.sv
// Shared types and constants for the test_runner sequencer.
package test_runner_pkg;

    localparam int MAX_TESTS = 32;
    localparam int IDX_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        REQ,
        RUN,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/test_runner_timer.sv
// Loadable saturating down-counter; expired is high whenever the count sits at zero.
module test_runner_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/test_runner.sv
// Sequencer that requests each attached test in turn and folds results into pass/fail.
// Watchdog per test is compiled in only when TEST_RUNNER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start after reset
// DELAY | start-up delay before first request
// REQ   | request asserted, waiting for busy
// RUN   | test busy, waiting for busy to fall
// NEXT  | advance to next test or finish
// DONE  | verdict valid, waiting for restart
module test_runner
    import test_runner_pkg::*;
#(
    parameter int NUM_TESTS   = 4,
    parameter int START_DELAY = 100,
    parameter int TIMEOUT     = 10000,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [NUM_TESTS-1:0] test_req,
    input  logic [NUM_TESTS-1:0] test_busy,
    input  logic [NUM_TESTS-1:0] test_return,
    output logic [IDX_W-1:0]     cur_index,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_TESTS-1:0] fail_mask,
    output logic [NUM_TESTS-1:0] timeout_mask
);

    localparam logic [CNT_W-1:0]     DELAY_LD = CNT_W'(START_DELAY);
    // Loaded with TIMEOUT-1 so expiry is seen on the TIMEOUT-th REQ/RUN cycle.
    localparam logic [CNT_W-1:0]     TO_LD    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_TESTS-1:0] ONE      = NUM_TESTS'(1);
    localparam logic [IDX_W-1:0]     LAST     = IDX_W'(NUM_TESTS - 1);

    state_t               state;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 expired;
    logic [NUM_TESTS-1:0] sel;
    logic                 busy_cur;
    logic                 ret_cur;
    logic                 last;

    assign sel      = ONE << cur_index;
    assign busy_cur = |(test_busy & sel);
    assign ret_cur  = |(test_return & sel);
    assign last     = (cur_index == LAST);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE, DONE: begin
                tmr_load = start;
                tmr_val  = DELAY_LD;
            end
            DELAY: begin
                tmr_load = expired;
                tmr_val  = TO_LD;
            end
            NEXT: begin
                tmr_load = !last;
                tmr_val  = TO_LD;
            end
            default: ;
        endcase
    end

    test_runner_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

`ifdef TEST_RUNNER_TIMEOUT_EN
    logic [NUM_TESTS-1:0] tmo_mask;
    assign timeout_mask = tmo_mask;
`else
    assign timeout_mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            test_req  <= '0;
            cur_index <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
`ifdef TEST_RUNNER_TIMEOUT_EN
            tmo_mask  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DELAY;
                        cur_index <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_mask <= '0;
`ifdef TEST_RUNNER_TIMEOUT_EN
                        tmo_mask  <= '0;
`endif
                    end
                end
                DELAY: begin
                    if (expired) begin
                        state    <= REQ;
                        test_req <= sel;
                    end
                end
                REQ: begin
                    // Busy already high on entry is a valid zero-latency acceptance.
                    if (busy_cur) begin
                        state    <= RUN;
                        test_req <= '0;
                    end
`ifdef TEST_RUNNER_TIMEOUT_EN
                    else if (expired) begin
                        state     <= NEXT;
                        test_req  <= '0;
                        fail_mask <= fail_mask | sel;
                        tmo_mask  <= tmo_mask | sel;
                    end
`endif
                end
                RUN: begin
                    // Busy falling takes priority over a coincident timeout.
                    if (!busy_cur) begin
                        state <= NEXT;
                        if (!ret_cur) begin
                            fail_mask <= fail_mask | sel;
                        end
                    end
`ifdef TEST_RUNNER_TIMEOUT_EN
                    else if (expired) begin
                        state     <= NEXT;
                        fail_mask <= fail_mask | sel;
                        tmo_mask  <= tmo_mask | sel;
                    end
`endif
                end
                NEXT: begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (fail_mask == '0);
                    end else begin
                        state     <= REQ;
                        cur_index <= cur_index + 1'b1;
                        test_req  <= sel << 1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_runner.sv
// Directed bench for test_runner with behavioural stub tests (4 tests, delay 100, timeout 50).
module tb_test_runner;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] test_req;
    logic [3:0] test_busy;
    logic [3:0] test_return;
    logic [4:0] cur_index;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [3:0] timeout_mask;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     = 0;
    int k      = 0;

    // Stub test modules: busy rises the cycle after req is seen, stays high len[i] cycles.
    logic [3:0] busy_r;
    logic [3:0] seen;
    logic [3:0] never;
    logic [3:0] ret;
    logic       clr_seen;
    int         len [4];
    int         bcnt [4];

    assign test_busy   = busy_r;
    assign test_return = ret;

    test_runner #(
        .NUM_TESTS   (4),
        .START_DELAY (100),
        .TIMEOUT     (50),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .test_req     (test_req),
        .test_busy    (test_busy),
        .test_return  (test_return),
        .cur_index    (cur_index),
        .done         (done),
        .pass         (pass),
        .fail_mask    (fail_mask),
        .timeout_mask (timeout_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (reset) begin
            busy_r <= '0;
            seen   <= '0;
        end else begin
            if (clr_seen) seen <= '0;
            for (int i = 0; i < 4; i++) begin
                if (busy_r[i]) begin
                    if (bcnt[i] <= 1) busy_r[i] <= 1'b0;
                    else bcnt[i] <= bcnt[i] - 1;
                end else if (test_req[i] && !never[i]) begin
                    busy_r[i] <= 1'b1;
                    bcnt[i]   <= len[i];
                    seen[i]   <= 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start    = 1'b1;
        clr_seen = 1'b1;
        tick();
        start    = 1'b0;
        clr_seen = 1'b0;
        t0       = cyc;
    endtask

    task automatic wait_done(input int budget);
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {28'd0, test_req}, 32'd0);
        chk({tag, "_idx"},   {27'd0, cur_index}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
        chk({tag, "_pass"},  {31'd0, pass}, 32'd0);
        chk({tag, "_fail"},  {28'd0, fail_mask}, 32'd0);
        chk({tag, "_tmo"},   {28'd0, timeout_mask}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        clr_seen = 1'b0;
        never    = 4'b0000;
        ret      = 4'b1111;
        for (int i = 0; i < 4; i++) len[i] = 5;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("por");

        // Run 1: all tests pass; done lands 101 + 4*8 cycles after start.
        do_start();
        wait_done(500);
        chk("r1_cycles", cyc - t0, 32'd133);
        chk("r1_pass", {31'd0, pass}, 32'd1);
        chk("r1_fail", {28'd0, fail_mask}, 32'd0);
        chk("r1_tmo", {28'd0, timeout_mask}, 32'd0);
        chk("r1_seen", {28'd0, seen}, 32'hf);
        chk("r1_idx", {27'd0, cur_index}, 32'd3);

        // Run 2: test 2 returns 0, test 3 still runs.
        ret = 4'b1011;
        do_start();
        wait_done(500);
        chk("r2_cycles", cyc - t0, 32'd133);
        chk("r2_fail", {28'd0, fail_mask}, 32'h4);
        chk("r2_tmo", {28'd0, timeout_mask}, 32'd0);
        chk("r2_pass", {31'd0, pass}, 32'd0);
        chk("r2_seen", {28'd0, seen}, 32'hf);

        // Run 3: restart from DONE clears masks; test 0 falls on the timeout cycle, test 1 hangs.
        ret      = 4'b1111;
        len[0]   = 48;
        never[1] = 1'b1;
        do_start();
        chk("r3_done_fall", {31'd0, done}, 32'd0);
        chk("r3_fail_clr", {28'd0, fail_mask}, 32'd0);
        chk("r3_idx0", {27'd0, cur_index}, 32'd0);
`ifdef TEST_RUNNER_TIMEOUT_EN
        while (timeout_mask == 4'd0 && (cyc - t0) < 400) tick();
        chk("r3_tmo_cycle", cyc - t0, 32'd202);
        chk("r3_tmo", {28'd0, timeout_mask}, 32'h2);
        chk("r3_fail", {28'd0, fail_mask}, 32'h2);
        chk("r3_req_drop", {28'd0, test_req}, 32'd0);
        tick();
        chk("r3_req_next", {28'd0, test_req}, 32'h4);
        wait_done(500);
        chk("r3_cycles", cyc - t0, 32'd219);
        chk("r3_pass", {31'd0, pass}, 32'd0);
        chk("r3_fail_end", {28'd0, fail_mask}, 32'h2);
`else
        repeat (300) tick();
        chk("r3_hang_done", {31'd0, done}, 32'd0);
        chk("r3_hang_tmo", {28'd0, timeout_mask}, 32'd0);
        chk("r3_hang_req", {28'd0, test_req}, 32'h2);
        chk("r3_hang_idx", {27'd0, cur_index}, 32'd1);
        chk("r3_hang_fail", {28'd0, fail_mask}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        // Run 4: test 0 still busy one cycle past the limit.
        never[1] = 1'b0;
        len[0]   = 49;
        do_start();
        wait_done(500);
`ifdef TEST_RUNNER_TIMEOUT_EN
        chk("r4_cycles", cyc - t0, 32'd176);
        chk("r4_tmo", {28'd0, timeout_mask}, 32'h1);
        chk("r4_fail", {28'd0, fail_mask}, 32'h1);
        chk("r4_pass", {31'd0, pass}, 32'd0);
`else
        chk("r4_cycles", cyc - t0, 32'd177);
        chk("r4_tmo", {28'd0, timeout_mask}, 32'd0);
        chk("r4_fail", {28'd0, fail_mask}, 32'd0);
        chk("r4_pass", {31'd0, pass}, 32'd1);
`endif

        // Run 5: reset while test 2 is in RUN.
        len[0] = 5;
        ret    = 4'b1110;
        do_start();
        while (!(cur_index == 5'd2 && test_req == 4'd0 && test_busy[2]) && (cyc - t0) < 400) tick();
        chk("r5_in_run2", {27'd0, cur_index}, 32'd2);
        chk("r5_fail_pre", {28'd0, fail_mask}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("mid_rst");

        // Run 6: rerun from test 0; start during RUN of test 1 is ignored.
        do_start();
        while (test_req == 4'd0 && (cyc - t0) < 400) tick();
        chk("r6_first_req", {28'd0, test_req}, 32'h1);
        chk("r6_first_idx", {27'd0, cur_index}, 32'd0);
        while (!(cur_index == 5'd1 && test_req == 4'd0 && test_busy[1]) && (cyc - t0) < 400) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(500);
        chk("r6_cycles", cyc - t0, 32'd133);
        chk("r6_fail", {28'd0, fail_mask}, 32'h1);
        chk("r6_pass", {31'd0, pass}, 32'd0);
        chk("r6_seen", {28'd0, seen}, 32'hf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
